// File: rtl/mini_src_pkg.sv
// rtl/mini_src_pkg.sv - Mini SRC opcodes, step encodings and instruction classes
package mini_src_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] NOP_OP  = OP_NOP;
    localparam logic [4:0] ADD_OP  = OP_ADD;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_T0     = 4'd1,
        ST_T1     = 4'd2,
        ST_T2     = 4'd3,
        ST_T3     = 4'd4,
        ST_T4     = 4'd5,
        ST_T5     = 4'd6,
        ST_T6     = 4'd7,
        ST_T7     = 4'd8,
        ST_HALTED = 4'd15
    } step_t;

    typedef enum logic [3:0] {
        CL_ALU3, CL_ALUI, CL_LDI, CL_LD, CL_ST,
        CL_MULDIV, CL_UNARY, CL_NOP, CL_HALT, CL_ILLEGAL
    } iclass_t;

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - IR/memory inputs and datapath strobes of the control unit
interface control_sequencer_if #(
    parameter int OPCODE_W = 5
);
    logic                run;
    logic [31:0]         IR;
    logic                mem_ready;
    logic                PCout, Zlowout, Zhighout, MDRout, Cout, BAout, Rout;
    logic                MARin, MDRin, IRin, PCin, Yin, Zin, HIin, LOin, Rin;
    logic                Gra, Grb, Grc;
    logic                IncPC, Read, Write;
    logic [OPCODE_W-1:0] alu_op;
    logic [3:0]          step;
    logic                halted;
    logic                illegal;

    modport master (
        input  run, IR, mem_ready,
        output PCout, Zlowout, Zhighout, MDRout, Cout, BAout, Rout,
        output MARin, MDRin, IRin, PCin, Yin, Zin, HIin, LOin, Rin,
        output Gra, Grb, Grc, IncPC, Read, Write,
        output alu_op, step, halted, illegal
    );

    modport slave (
        output run, IR, mem_ready,
        input  PCout, Zlowout, Zhighout, MDRout, Cout, BAout, Rout,
        input  MARin, MDRin, IRin, PCin, Yin, Zin, HIin, LOin, Rin,
        input  Gra, Grb, Grc, IncPC, Read, Write,
        input  alu_op, step, halted, illegal
    );
endinterface

// File: rtl/opcode_classifier.sv
// rtl/opcode_classifier.sv - combinational opcode-to-instruction-class decoder
module opcode_classifier
    import mini_src_pkg::*;
(
    input  logic [4:0] i_opcode,
    output iclass_t    o_class
);
    always_comb begin
        o_class = CL_ILLEGAL;
        case (i_opcode)
            OP_LD:                   o_class = CL_LD;
            OP_LDI:                  o_class = CL_LDI;
            OP_ST:                   o_class = CL_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:
                                     o_class = CL_ALU3;
            OP_ADDI, OP_ANDI, OP_ORI: o_class = CL_ALUI;
            OP_DIV, OP_MUL:          o_class = CL_MULDIV;
            OP_NEG, OP_NOT:          o_class = CL_UNARY;
            OP_NOP:                  o_class = CL_NOP;
            OP_HALT:                 o_class = CL_HALT;
            default:                 o_class = CL_ILLEGAL;
        endcase
    end
endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Mini SRC control unit: fetch T0-T2, class-specific execute T3-T7
module control_sequencer #(
    parameter int                  OPCODE_W      = 5,
    parameter bit                  MEM_HANDSHAKE = 1'b1,
    parameter logic [OPCODE_W-1:0] NOP_OP        = OPCODE_W'(mini_src_pkg::NOP_OP),
    parameter logic [OPCODE_W-1:0] ADD_OP        = OPCODE_W'(mini_src_pkg::ADD_OP)
) (
    input logic                 clock,
    input logic                 clear,
    control_sequencer_if.master bus
);
    import mini_src_pkg::*;

    step_t      r_step;
    step_t      w_next;
    iclass_t    w_class;
    logic [4:0] w_opcode;
    logic       w_mem_done;
    logic       w_unused_ir;

    assign w_opcode    = bus.IR[31:27];
    assign w_unused_ir = ^bus.IR[26:0];
    assign w_mem_done  = !MEM_HANDSHAKE || bus.mem_ready;
    assign bus.step    = r_step;

    opcode_classifier u_classifier (
        .i_opcode (w_opcode),
        .o_class  (w_class)
    );

    always_ff @(posedge clock) begin
        if (clear) r_step <= ST_IDLE;
        else       r_step <= w_next;
    end

    always_comb begin
        w_next       = r_step;
        bus.PCout    = 1'b0; bus.Zlowout = 1'b0; bus.Zhighout = 1'b0; bus.MDRout = 1'b0;
        bus.Cout     = 1'b0; bus.BAout   = 1'b0; bus.Rout     = 1'b0;
        bus.MARin    = 1'b0; bus.MDRin   = 1'b0; bus.IRin     = 1'b0; bus.PCin   = 1'b0;
        bus.Yin      = 1'b0; bus.Zin     = 1'b0; bus.HIin     = 1'b0; bus.LOin   = 1'b0;
        bus.Rin      = 1'b0; bus.Gra     = 1'b0; bus.Grb      = 1'b0; bus.Grc    = 1'b0;
        bus.IncPC    = 1'b0; bus.Read    = 1'b0; bus.Write    = 1'b0;
        bus.halted   = 1'b0; bus.illegal = 1'b0;
        bus.alu_op   = NOP_OP;

        case (r_step)
            ST_IDLE: if (bus.run) w_next = ST_T0;
            ST_T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
                bus.alu_op = ADD_OP;
                w_next = ST_T1;
            end
            ST_T1: begin
                bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
                if (w_mem_done) w_next = ST_T2;
            end
            ST_T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
                w_next = ST_T3;
            end
            ST_T3: begin
                w_next = ST_T4;
                case (w_class)
                    CL_ALU3, CL_ALUI:   begin bus.Grb = 1'b1; bus.Rout  = 1'b1; bus.Yin = 1'b1; end
                    CL_LDI, CL_LD, CL_ST: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
                    CL_MULDIV:          begin bus.Gra = 1'b1; bus.Rout  = 1'b1; bus.Yin = 1'b1; end
                    CL_UNARY: begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1;
                        bus.alu_op = OPCODE_W'(w_opcode);
                    end
                    CL_HALT:    w_next = ST_HALTED;
                    CL_ILLEGAL: begin bus.illegal = 1'b1; w_next = ST_T0; end
                    default:    w_next = ST_T0;
                endcase
            end
            ST_T4: begin
                w_next = (w_class == CL_UNARY) ? ST_T0 : ST_T5;
                case (w_class)
                    CL_ALU3: begin
                        bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1;
                        bus.alu_op = OPCODE_W'(w_opcode);
                    end
                    CL_MULDIV: begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1;
                        bus.alu_op = OPCODE_W'(w_opcode);
                    end
                    CL_ALUI: begin
                        bus.Cout = 1'b1; bus.Zin = 1'b1;
                        if (w_opcode == OP_ANDI)     bus.alu_op = OPCODE_W'(OP_AND);
                        else if (w_opcode == OP_ORI) bus.alu_op = OPCODE_W'(OP_OR);
                        else                         bus.alu_op = ADD_OP;
                    end
                    CL_LDI, CL_LD, CL_ST: begin
                        bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = ADD_OP;
                    end
                    CL_UNARY: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                    default: ;
                endcase
            end
            ST_T5: begin
                w_next = ST_T0;
                case (w_class)
                    CL_ALU3, CL_ALUI, CL_LDI: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                    CL_LD, CL_ST: begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; w_next = ST_T6; end
                    CL_MULDIV:    begin bus.Zlowout = 1'b1; bus.LOin  = 1'b1; w_next = ST_T6; end
                    default: ;
                endcase
            end
            ST_T6: begin
                w_next = ST_T0;
                case (w_class)
                    CL_LD: begin
                        bus.Read = 1'b1; bus.MDRin = 1'b1;
                        w_next = w_mem_done ? ST_T7 : ST_T6;
                    end
                    // Read stays low so the MDR takes the register value from the bus
                    CL_ST:     begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; w_next = ST_T7; end
                    CL_MULDIV: begin bus.Zhighout = 1'b1; bus.HIin = 1'b1; end
                    default: ;
                endcase
            end
            ST_T7: begin
                w_next = ST_T0;
                case (w_class)
                    CL_LD: begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                    CL_ST: begin
                        bus.Write = 1'b1;
                        if (!w_mem_done) w_next = ST_T7;
                    end
                    default: ;
                endcase
            end
            ST_HALTED: bus.halted = 1'b1;
            default:   w_next = ST_IDLE;
        endcase
    end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired, parametrised control unit for the Mini SRC datapath.
- Sequences fetch (T0–T2), then opcode-specific execute steps (T3–T7), driving the same strobes the datapath benches drive by hand.
- Adds decode of the IR, optional memory-ready wait states, HALT, and an illegal-opcode flag.
- Sits between the IR/memory interface and the bus/register-select logic.

Parameters:
- OPCODE_W, 5: width of the opcode field IR[31:27] and of alu_op.
- MEM_HANDSHAKE, 1: 1 = memory steps stall on mem_ready; 0 = every step takes exactly one cycle.
- NOP_OP, 5'b11010: alu_op value driven whenever the ALU is idle.
- ADD_OP, 5'b00011: alu_op used for PC increment and for address/immediate adds.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  reset, synchronous, active-high.
- run  in  1  leave IDLE and begin fetching.
- IR  in  32  instruction register contents; opcode at [31:27].
- mem_ready  in  1  memory has completed the current Read/Write.
- PCout, Zlowout, Zhighout, MDRout, Cout, BAout, Rout  out  1 each  bus drivers.
- MARin, MDRin, IRin, PCin, Yin, Zin, HIin, LOin, Rin  out  1 each  register loads.
- Gra, Grb, Grc  out  1 each  register-field selects.
- IncPC, Read, Write  out  1 each  PC increment and memory strobes.
- alu_op  out  OPCODE_W  ALU operation.
- step  out  4  current step, for debug: IDLE=0, T0..T7=1..8, HALTED=15.
- halted  out  1  HALT executed.
- illegal  out  1  one-cycle pulse at T3 for an undefined opcode.

Behaviour:
- Moore machine: every output is a function of the registered step and IR only.
- clear at a clock edge sends the step to IDLE from any state, including mid-instruction and while stalled. IDLE drives every output 0, alu_op=NOP_OP, halted=0.
- Any output not named in the current step is 0; alu_op is NOP_OP whenever it is not named.
- IDLE: moves to T0 on the first edge with run=1.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin, alu_op=ADD_OP.
  - T1: Zlowout, PCin, Read, MDRin. This is a memory step.
  - T2: MDRout, IRin.
- Execute, selected by decoding IR in T3. Every instruction class returns to T0 after its last step.
  - ALU3 (add, sub, and, or, ror, rol, shr, shra, shl; 00011–01011):
    - T3: Grb Rout Yin.
    - T4: Grc Rout Zin, alu_op=opcode.
    - T5: Zlowout Gra Rin.
  - ALUI (addi/andi/ori, 01100–01110):
    - T3: Grb Rout Yin.
    - T4: Cout Zin, alu_op=ADD/AND/OR respectively.
    - T5: Zlowout Gra Rin.
  - LDI (00001):
    - T3: Grb BAout Yin.
    - T4: Cout Zin, alu_op=ADD_OP.
    - T5: Zlowout Gra Rin.
  - LD (00000): T3 and T4 as LDI, then:
    - T5: Zlowout MARin.
    - T6: Read MDRin. This is a memory step.
    - T7: MDRout Gra Rin.
  - ST (00010): T3–T5 as LD, then:
    - T6: Gra Rout MDRin (Read=0, so MDR loads from the bus).
    - T7: Write. This is a memory step.
  - MUL/DIV (10000/01111):
    - T3: Gra Rout Yin.
    - T4: Grb Rout Zin, alu_op=opcode.
    - T5: Zlowout LOin.
    - T6: Zhighout HIin.
  - NEG/NOT (10001/10010):
    - T3: Grb Rout Zin, alu_op=opcode.
    - T4: Zlowout Gra Rin.
  - NOP (11010): T3 drives nothing, then T0.
  - HALT (11011): T3 moves to HALTED. HALTED sets halted=1 and all strobes 0, and is left only via clear.
  - Undefined opcode: behaves as NOP, with illegal=1 during T3.
- Memory steps:
  - With MEM_HANDSHAKE=1, the step holds with its outputs asserted until an edge with mem_ready=1, then advances.
  - A mem_ready already high on entry gives a single-cycle step.
  - With MEM_HANDSHAKE=0, mem_ready is ignored.
- run is sampled only in IDLE; deasserting it mid-instruction has no effect.

Decomposition:
- Package mini_src_pkg holds:
  - opcode localparams (LD..HALT, NOP_OP, ADD_OP);
  - step encodings (IDLE, T0..T7, HALTED);
  - an instruction-class enum (ALU3, ALUI, LDI, LD, ST, MULDIV, UNARY, NOP, HALT, ILLEGAL).
- One natural sub-module: opcode_classifier, a combinational opcode-to-class decoder.

Test Plan:
- Reset: clear=1 for 2 cycles, then run=0 → step=0, all strobes 0, alu_op=11010; run=1 → T0 on the next edge with PCout=MARin=IncPC=Zin=1.
- add R5,R2,R4 (IR=0x1A920000), mem_ready tied 1 → 6 cycles T0–T5. Checks:
  - T4: Grc=Rout=Zin=1 and alu_op=00011.
  - T5: Gra=Rin=1.
  - Next cycle returns to T0.
- ld R2,0x95(R0) (IR=0x01000095), mem_ready low for 3 cycles in T6 → T6 lasts 4 cycles with Read=MDRin=1 throughout; T7: MDRout=Gra=Rin=1. Total 11 cycles.
- mul R3,R1 (opcode 10000) → T5: Zlowout=LOin=1; T6: Zhighout=HIin=1; then T0.
- HALT (IR=0xD8000000) → HALTED after T3; halted=1 held for 20 cycles, all strobes 0; clear → IDLE, halted=0.
- clear asserted during a stalled LD T6 → next step=IDLE, Read=0. Undefined opcode 11111 → illegal=1 for exactly one cycle (T3), then T0.
